acondicionador_botones: RTL and testbench
=========================================

Name: acondicionador_botones

Overview:
- Upstream input stage of the tic-tac-toe controller.
- Takes the five raw, asynchronous push-button levels (up, down, left, right, select).
- Synchronises, debounces, arbitrates and converts them into single-cycle, mutually exclusive command pulses.
- These pulses drive the controller's boton_*_reg inputs directly.

Parameters:
- N_DEB, 500000: consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz); legal range ≥ 2.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > N_DEB.
- REPEAT_DLY, 25000000: cycles a held direction button waits before its first auto-repeat (optional feature only).
- REPEAT_PER, 10000000: cycles between subsequent auto-repeats (optional feature only).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- habilita  in  1  1 = pulses may be emitted; 0 = new presses discarded
- btn_arriba_in  in  1  raw up button, asynchronous
- btn_abajo_in  in  1  raw down button, asynchronous
- btn_izq_in  in  1  raw left button, asynchronous
- btn_der_in  in  1  raw right button, asynchronous
- btn_elige_in  in  1  raw select button, asynchronous
- boton_arriba_reg  out  1  one-cycle up pulse
- boton_abajo_reg  out  1  one-cycle down pulse
- boton_izq_reg  out  1  one-cycle left pulse
- boton_der_reg  out  1  one-cycle right pulse
- boton_elige_reg  out  1  one-cycle select pulse
- nivel_estable  out  5  debounced levels {elige, der, izq, abajo, arriba}

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: sync flops, counters, debounced levels, all pulse outputs and nivel_estable are 0; FSM enters IDLE.
- A button held through reset is seen as a new press once debounced.
- Synchroniser: two flops per input, no combinational use of raw inputs.
- Debounce, per button, independent:
  - Counter clears whenever synced value == debounced level.
  - Otherwise it increments; when it is N_DEB-1 and still mismatched, the debounced level flips and the counter clears.
  - Glitches shorter than N_DEB cycles never change the level.
- Latency: if raw input is first sampled high at edge k, the debounced level rises at edge k+1+N_DEB and the pulse is high for exactly the cycle after edge k+2+N_DEB. Release timing is symmetric.
- Rise event: debounced level 0→1 for a button.
- FSM states:
  - IDLE: on any rise event with habilita=1, register exactly one pulse, chosen by priority elige > arriba > abajo > izq > der; lower-priority simultaneous rises are dropped, not queued. Go to ESPERA. With habilita=0 a rise event emits nothing and still goes to ESPERA.
  - ESPERA: no pulses (unless the optional feature applies). Return to IDLE only in the cycle after all five debounced levels are 0.
- Consequence: a second button pressed while the first is held never produces a pulse; at most one pulse per press-release episode.
- At most one output high in any cycle; every output pulse is exactly 1 cycle wide.
- Mid-operation reset: any pending pulse is cancelled and counters clear; outputs are 0 in the cycle after the reset edge.
- habilita dropping in the same cycle a pulse is being registered: the pulse is suppressed.

Optional Feature:
- Macro: GATO_AUTO_REPEAT_EN.
- Defined:
  - In ESPERA, if exactly one debounced level is high and it is a direction button (not elige), a repeat counter runs.
  - After REPEAT_DLY cycles one pulse is issued on that button, then one every REPEAT_PER cycles while held and habilita=1.
  - The counter clears when the held set changes or habilita=0.
- Not defined: no repeat counter logic exists; exactly one pulse per press.

Decomposition:
- Package gato_botones_pkg:
  - button index constants: ARRIBA=0, ABAJO=1, IZQ=2, DER=3, ELIGE=4.
  - FSM state encoding: IDLE, ESPERA.
  - Priority order table.
  - Default N_DEB / REPEAT constants.
- Sub-module antirrebote_bit: synchroniser plus debounce counter for one button, parameterised by N_DEB and CNT_W; instantiated five times.
- Arbitration, FSM and repeat logic stay in the top.

Test Plan (bench uses N_DEB=4, REPEAT_DLY=10, REPEAT_PER=5):
- Raw arriba high from edge 10, held 20 cycles, habilita=1 → boton_arriba_reg high only in the cycle after edge 16; nivel_estable[0]=1 from edge 15; no further pulses.
- Raw izq toggling every 2 cycles for 30 cycles → no pulse, nivel_estable stays 0.
- elige and der rise on the same cycle → only boton_elige_reg pulses; after both release and der is pressed again → boton_der_reg pulses once.
- arriba held, abajo pressed and released during the hold → only one arriba pulse; no abajo pulse.
- Press with habilita=0, then set habilita=1 while still held → no pulse until release and re-press.
- Reset asserted the cycle before an expected pulse → no pulse; all outputs 0; fresh press afterwards behaves as in the first scenario.
- With GATO_AUTO_REPEAT_EN, hold der 40 cycles → first pulse at debounce, then pulses 10 cycles later and every 5 cycles after that. Without the macro → single pulse.

Source files
------------

// File: rtl/gato_botones_pkg.sv
// Shared constants for the tic-tac-toe button conditioner: button indices,
// FSM encoding, arbitration priority and default timing values.
package gato_botones_pkg;

  localparam logic [2:0] ARRIBA = 3'd0;
  localparam logic [2:0] ABAJO  = 3'd1;
  localparam logic [2:0] IZQ    = 3'd2;
  localparam logic [2:0] DER    = 3'd3;
  localparam logic [2:0] ELIGE  = 3'd4;

  localparam int unsigned NUM_BOTONES = 5;

  typedef enum logic {
    IDLE,
    ESPERA
  } estado_e;

  // Highest priority first.
  localparam logic [2:0] PRIORIDAD [NUM_BOTONES] = '{ELIGE, ARRIBA, ABAJO, IZQ, DER};

  localparam int unsigned N_DEB_DEF      = 500000;
  localparam int unsigned CNT_W_DEF      = 20;
  localparam int unsigned REPEAT_DLY_DEF = 25000000;
  localparam int unsigned REPEAT_PER_DEF = 10000000;

endpackage

// File: rtl/antirrebote_bit.sv
// Two-flop synchroniser plus debounce counter for a single raw button level.
module antirrebote_bit #(
  parameter int unsigned N_DEB = 500000,
  parameter int unsigned CNT_W = 20
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic nivel_o
);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nivel_q, nivel_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    cnt_d   = cnt_q;
    nivel_d = nivel_q;
    if (sync_q[1] == nivel_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(N_DEB - 1)) begin
      nivel_d = ~nivel_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      nivel_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      nivel_q <= nivel_d;
    end
  end

  assign nivel_o = nivel_q;

endmodule

// File: rtl/acondicionador_botones.sv
// Button conditioner: debounce, priority arbitration and one-pulse-per-press FSM.
// Optional auto-repeat of a held direction button under GATO_AUTO_REPEAT_EN.
module acondicionador_botones
  import gato_botones_pkg::*;
#(
  parameter int unsigned N_DEB      = N_DEB_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_PER = REPEAT_PER_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       habilita,
  input  logic       btn_arriba_in,
  input  logic       btn_abajo_in,
  input  logic       btn_izq_in,
  input  logic       btn_der_in,
  input  logic       btn_elige_in,
  output logic       boton_arriba_reg,
  output logic       boton_abajo_reg,
  output logic       boton_izq_reg,
  output logic       boton_der_reg,
  output logic       boton_elige_reg,
  output logic [4:0] nivel_estable
);

  if (N_DEB < 2) begin : g_err_ndeb
    $error("N_DEB must be at least 2");
  end
  if ((64'd1 << CNT_W) <= 64'(N_DEB)) begin : g_err_cntw
    $error("CNT_W too narrow for N_DEB");
  end
  if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_err_rep
    $error("REPEAT_DLY and REPEAT_PER must be non-zero");
  end

  logic [4:0] btn_raw;
  logic [4:0] nivel;
  logic [4:0] nivel_prev_q;
  logic [4:0] subida;
  logic [4:0] sel;
  logic [4:0] pulso_q;
  estado_e    estado_q;

  assign btn_raw = {btn_elige_in, btn_der_in, btn_izq_in, btn_abajo_in, btn_arriba_in};

  for (genvar g = 0; g < 5; g++) begin : g_deb
    antirrebote_bit #(
      .N_DEB(N_DEB),
      .CNT_W(CNT_W)
    ) u_deb (
      .clk_i  (clk),
      .reset_i(reset),
      .btn_i  (btn_raw[g]),
      .nivel_o(nivel[g])
    );
  end

  assign subida = nivel & ~nivel_prev_q;

  // Only the highest-priority rise survives; the rest are dropped.
  always_comb begin
    logic hallado;
    sel     = '0;
    hallado = 1'b0;
    for (int unsigned i = 0; i < NUM_BOTONES; i++) begin
      if (!hallado && subida[PRIORIDAD[i[2:0]]]) begin
        sel[PRIORIDAD[i[2:0]]] = 1'b1;
        hallado                = 1'b1;
      end
    end
  end

`ifdef GATO_AUTO_REPEAT_EN
  logic        unico_dir;
  logic        rep_activo;
  logic        rep_disparo;
  logic        rep_sig_q;
  logic [31:0] rep_cnt_q;
  logic [31:0] rep_limite;

  assign unico_dir   = (nivel != '0) && ((nivel & (nivel - 5'd1)) == '0) && !nivel[ELIGE];
  // Any change in the held set, or disabling, restarts the repeat timing.
  assign rep_activo  = (estado_q == ESPERA) && habilita && unico_dir && (nivel == nivel_prev_q);
  assign rep_limite  = rep_sig_q ? 32'(REPEAT_PER) : 32'(REPEAT_DLY);
  assign rep_disparo = rep_activo && (rep_cnt_q == rep_limite - 32'd1);

  always_ff @(posedge clk) begin
    if (reset || !rep_activo) begin
      rep_cnt_q <= '0;
      rep_sig_q <= 1'b0;
    end else if (rep_disparo) begin
      rep_cnt_q <= '0;
      rep_sig_q <= 1'b1;
    end else begin
      rep_cnt_q <= rep_cnt_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q     <= IDLE;
      pulso_q      <= '0;
      nivel_prev_q <= '0;
    end else begin
      nivel_prev_q <= nivel;
      pulso_q      <= '0;
      case (estado_q)
        IDLE: begin
          if (subida != '0) begin
            estado_q <= ESPERA;
            if (habilita) pulso_q <= sel;
          end
        end
        ESPERA: begin
          if (nivel == '0) estado_q <= IDLE;
`ifdef GATO_AUTO_REPEAT_EN
          if (rep_disparo) pulso_q <= nivel;
`endif
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign boton_arriba_reg = pulso_q[ARRIBA];
  assign boton_abajo_reg  = pulso_q[ABAJO];
  assign boton_izq_reg    = pulso_q[IZQ];
  assign boton_der_reg    = pulso_q[DER];
  assign boton_elige_reg  = pulso_q[ELIGE];
  assign nivel_estable    = nivel;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench for acondicionador_botones with short debounce/repeat timing.
module tb_acondicionador_botones;

  localparam int unsigned NDeb   = 4;
  localparam int unsigned CntW   = 3;
  localparam int unsigned RepDly = 10;
  localparam int unsigned RepPer = 5;

`ifdef GATO_AUTO_REPEAT_EN
  localparam int S1Pulsos  = 3;
  localparam int S7Pulsos  = 7;
  localparam int S7UltOfs  = 41;
`else
  localparam int S1Pulsos  = 1;
  localparam int S7Pulsos  = 1;
  localparam int S7UltOfs  = 6;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       habilita;
  logic [4:0] btn;
  logic       b_arriba, b_abajo, b_izq, b_der, b_elige;
  logic [4:0] nivel;
  logic [4:0] pulsos;

  acondicionador_botones #(
    .N_DEB     (NDeb),
    .CNT_W     (CntW),
    .REPEAT_DLY(RepDly),
    .REPEAT_PER(RepPer)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .habilita        (habilita),
    .btn_arriba_in   (btn[0]),
    .btn_abajo_in    (btn[1]),
    .btn_izq_in      (btn[2]),
    .btn_der_in      (btn[3]),
    .btn_elige_in    (btn[4]),
    .boton_arriba_reg(b_arriba),
    .boton_abajo_reg (b_abajo),
    .boton_izq_reg   (b_izq),
    .boton_der_reg   (b_der),
    .boton_elige_reg (b_elige),
    .nivel_estable   (nivel)
  );

  assign pulsos = {b_elige, b_der, b_izq, b_abajo, b_arriba};

  always #5 clk = ~clk;

  int ciclo = 0;
  always @(posedge clk) ciclo <= ciclo + 1;

  int checks = 0;
  int errors = 0;
  int n_pulsos [5];
  int prim [5];
  int ult [5];
  int multi = 0;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic esperar(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic limpiar();
    for (int i = 0; i < 5; i++) begin
      n_pulsos[i] = 0;
      prim[i]     = 0;
      ult[i]      = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        if (pulsos[i[2:0]]) begin
          if (n_pulsos[i] == 0) prim[i] = ciclo;
          n_pulsos[i]++;
          ult[i] = ciclo;
        end
      end
      if ($countones(pulsos) > 1) multi++;
    end
  end

  initial begin
    int k;
    int alto;
    reset    = 1'b1;
    habilita = 1'b1;
    btn      = '0;
    limpiar();
    esperar(3);
    comprobar("reset_pulsos", 32'(pulsos), 32'd0);
    comprobar("reset_nivel", 32'(nivel), 32'd0);
    reset = 1'b0;
    esperar(2);

    // S1: single arriba press, exact latency.
    limpiar();
    btn[0] = 1'b1;
    k = ciclo + 1;
    esperar(5);
    comprobar("s1_nivel_antes", 32'(nivel[0]), 32'd0);
    esperar(1);
    comprobar("s1_nivel_sube", 32'(nivel[0]), 32'd1);
    comprobar("s1_sin_pulso_aun", 32'(pulsos), 32'd0);
    esperar(1);
    comprobar("s1_pulso", 32'(pulsos), 32'b00001);
    esperar(1);
    comprobar("s1_pulso_ancho", 32'(pulsos), 32'd0);
    esperar(12);
    btn[0] = 1'b0;
    esperar(12);
    comprobar("s1_n_arriba", 32'(n_pulsos[0]), 32'(S1Pulsos));
    comprobar("s1_ciclo_pulso", 32'(prim[0]), 32'(k + 6));
    comprobar("s1_otros", 32'(n_pulsos[1] + n_pulsos[2] + n_pulsos[3] + n_pulsos[4]), 32'd0);

    // S2: izq bouncing every 2 cycles never settles.
    limpiar();
    alto = 0;
    for (int j = 0; j < 30; j++) begin
      if (j % 2 == 0) btn[2] = ~btn[2];
      esperar(1);
      if (nivel[2]) alto++;
    end
    btn[2] = 1'b0;
    esperar(10);
    comprobar("s2_nivel_izq", 32'(alto), 32'd0);
    comprobar("s2_n_izq", 32'(n_pulsos[2]), 32'd0);

    // S3: simultaneous elige+der, then der alone.
    limpiar();
    btn[4] = 1'b1;
    btn[3] = 1'b1;
    esperar(10);
    btn[4] = 1'b0;
    btn[3] = 1'b0;
    esperar(12);
    comprobar("s3_n_elige", 32'(n_pulsos[4]), 32'd1);
    comprobar("s3_n_der_simult", 32'(n_pulsos[3]), 32'd0);
    limpiar();
    btn[3] = 1'b1;
    esperar(10);
    btn[3] = 1'b0;
    esperar(12);
    comprobar("s3_n_der", 32'(n_pulsos[3]), 32'd1);
    comprobar("s3_n_elige_2", 32'(n_pulsos[4]), 32'd0);

    // S4: abajo pressed and released while arriba is held.
    limpiar();
    btn[0] = 1'b1;
    esperar(7);
    btn[1] = 1'b1;
    esperar(5);
    btn[1] = 1'b0;
    esperar(2);
    btn[0] = 1'b0;
    esperar(12);
    comprobar("s4_n_arriba", 32'(n_pulsos[0]), 32'd1);
    comprobar("s4_n_abajo", 32'(n_pulsos[1]), 32'd0);

    // S5: press while disabled, enable mid-hold, then re-press.
    limpiar();
    habilita = 1'b0;
    btn[0]   = 1'b1;
    esperar(9);
    habilita = 1'b1;
    esperar(1);
    btn[0] = 1'b0;
    esperar(12);
    comprobar("s5_sin_pulso", 32'(n_pulsos[0]), 32'd0);
    limpiar();
    btn[0] = 1'b1;
    k = ciclo + 1;
    esperar(8);
    btn[0] = 1'b0;
    esperar(12);
    comprobar("s5_repulsa_n", 32'(n_pulsos[0]), 32'd1);
    comprobar("s5_repulsa_ciclo", 32'(prim[0]), 32'(k + 6));

    // S5b: habilita drops in the cycle the pulse is registered.
    limpiar();
    btn[2] = 1'b1;
    esperar(6);
    habilita = 1'b0;
    esperar(1);
    habilita = 1'b1;
    esperar(2);
    btn[2] = 1'b0;
    esperar(12);
    comprobar("s5b_suprimido", 32'(n_pulsos[2]), 32'd0);

    // S6: reset one cycle before the expected pulse.
    limpiar();
    btn[0] = 1'b1;
    esperar(6);
    reset = 1'b1;
    esperar(1);
    comprobar("s6_pulsos_reset", 32'(pulsos), 32'd0);
    comprobar("s6_nivel_reset", 32'(nivel), 32'd0);
    reset  = 1'b0;
    btn[0] = 1'b0;
    esperar(12);
    comprobar("s6_sin_pulso", 32'(n_pulsos[0]), 32'd0);
    limpiar();
    btn[0] = 1'b1;
    k = ciclo + 1;
    esperar(8);
    btn[0] = 1'b0;
    esperar(12);
    comprobar("s6_fresco_n", 32'(n_pulsos[0]), 32'd1);
    comprobar("s6_fresco_ciclo", 32'(prim[0]), 32'(k + 6));

    // S7: der held 40 cycles (auto-repeat when enabled).
    limpiar();
    btn[3] = 1'b1;
    k = ciclo + 1;
    esperar(40);
    btn[3] = 1'b0;
    esperar(14);
    comprobar("s7_n_der", 32'(n_pulsos[3]), 32'(S7Pulsos));
    comprobar("s7_primer", 32'(prim[3]), 32'(k + 6));
    comprobar("s7_ultimo", 32'(ult[3]), 32'(k + S7UltOfs));

    comprobar("un_solo_pulso", 32'(multi), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
